pc_unit: RTL

- Parametrised fetch-stage program counter.
- Selects the next PC each cycle from five sources:
  - exception vector
  - execute-stage branch
  - decode-stage return
  - decode-stage jump
  - sequential increment
- Supports a fetch stall.
- Maintains a small return-address stack (RAS) for call/return prediction.
- Drives instruction-memory address and a one-cycle redirect pulse used by the pipeline flush logic.

---
 rtl/pc_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with a small return-address stack.
// Each rising edge selects the next fetch PC. Sources, highest priority first:
// exception vector, execute-stage branch, decode-stage return (RAS pop),
// decode-stage jump (optional RAS push), stall hold, sequential increment.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   stall             hold the PC; any redirect overrides it
//   exc_valid         exception redirect to EXC_VECTOR; clears the RAS
//   br_taken/br_target         taken-branch redirect
//   ret_valid/ret_fallback     return: pop RAS, or use the fallback when empty
//   jmp_valid/jmp_target       jump redirect
//   jmp_link/link_addr         the jump is a call: push link_addr
//   pc_count          current fetch PC (registered)
//   pc_plus           pc_count + PC_INC (combinational)
//   redirect          high the cycle after a non-sequential load (registered)
//   ras_empty/ras_full         RAS occupancy flags, derived from the registered count
module pc_unit #(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR   = PC_WIDTH'(32'h0000_0100),
  parameter int unsigned         PC_INC       = 4,
  parameter int unsigned         ALIGN_BITS   = 2,
  parameter int unsigned         RAS_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                exc_valid,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                ret_valid,
  input  logic [PC_WIDTH-1:0] ret_fallback,
  input  logic                jmp_valid,
  input  logic [PC_WIDTH-1:0] jmp_target,
  input  logic                jmp_link,
  input  logic [PC_WIDTH-1:0] link_addr,
  output logic [PC_WIDTH-1:0] pc_count,
  output logic [PC_WIDTH-1:0] pc_plus,
  output logic                redirect,
  output logic                ras_empty,
  output logic                ras_full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {PC_WIDTH{1'b1}} << ALIGN_BITS;

  // ras_ptr points at the next free slot. The top entry is therefore at
  // ras_ptr-1. When the stack is full, the slot at ras_ptr holds the oldest
  // entry, so a push there overwrites it.
  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    ras_ptr;
  logic [CNT_W-1:0]    ras_count;
  logic [PC_WIDTH-1:0] ras_top;

  logic [PC_WIDTH-1:0] pc_next;
  logic                redirect_next;
  logic                push;
  logic                pop;
  logic                clear;

  assign pc_plus   = pc_count + PC_WIDTH'(PC_INC);
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
  assign ras_top   = ras_mem[ras_ptr - PTR_W'(1)];

  // Next-PC select; only the winning source may touch the RAS.
  always_comb begin
    pc_next       = pc_plus;
    redirect_next = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    clear         = 1'b0;
    if (exc_valid) begin
      pc_next       = EXC_VECTOR & ALIGN_MASK;
      redirect_next = 1'b1;
      clear         = 1'b1;
    end else if (br_taken) begin
      pc_next       = br_target & ALIGN_MASK;
      redirect_next = 1'b1;
    end else if (ret_valid) begin
      redirect_next = 1'b1;
      if (ras_empty) begin
        pc_next = ret_fallback & ALIGN_MASK;
      end else begin
        pc_next = ras_top & ALIGN_MASK;
        pop     = 1'b1;
      end
    end else if (jmp_valid) begin
      pc_next       = jmp_target & ALIGN_MASK;
      redirect_next = 1'b1;
      push          = jmp_link;
    end else if (stall) begin
      pc_next = pc_count;
    end
  end

  // PC, redirect flag and RAS bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_count  <= RESET_VECTOR;
      redirect  <= 1'b0;
      ras_ptr   <= '0;
      ras_count <= '0;
    end else begin
      pc_count <= pc_next;
      redirect <= redirect_next;
      if (clear) begin
        ras_count <= '0;
      end else if (push) begin
        ras_ptr <= ras_ptr + PTR_W'(1);
        if (!ras_full) ras_count <= ras_count + CNT_W'(1);
      end else if (pop) begin
        ras_ptr   <= ras_ptr - PTR_W'(1);
        ras_count <= ras_count - CNT_W'(1);
      end
    end
  end

  // RAS storage. The contents do not need a reset.
  always_ff @(posedge clk) begin
    if (push) ras_mem[ras_ptr] <= link_addr;
  end

endmodule
